// File: rtl/timekeeper_ctrl.sv
// timekeeper_ctrl: HH:MM:SS time-of-day keeper with field editing, an armable
// alarm with auto-repeat editing, and optional 12-hour display. Drives eight
// digit codes {en, value[3:0], dp} for dspl_drv_8dig (d8 is leftmost).
module timekeeper_ctrl #(
    parameter int HOUR_12     = 0,
    parameter int REPEAT_HOLD = 2,
    parameter int ALARM_LEN_S = 60
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pulse_1hz,
    input  logic       pulse_500ms,
    input  logic       mode_button,
    input  logic       add_button,
    input  logic       sub_button,
    output logic [5:0] d1,
    output logic [5:0] d2,
    output logic [5:0] d3,
    output logic [5:0] d4,
    output logic [5:0] d5,
    output logic [5:0] d6,
    output logic [5:0] d7,
    output logic [5:0] d8,
    output logic       alarm_o,
    output logic [2:0] mode_o
);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_H  = 3'd1,
        SET_M  = 3'd2,
        SET_S  = 3'd3,
        SET_AH = 3'd4,
        SET_AM = 3'd5
    } state_t;

    localparam logic [3:0] HOLD      = 4'(REPEAT_HOLD);
    localparam logic [7:0] ALARM_END = 8'(ALARM_LEN_S - 1);
    localparam logic [5:0] DIG_ZERO    = 6'b10_0000;
    localparam logic [5:0] DIG_ZERO_DP = 6'b10_0001;

    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] maxv);
        return (v == maxv) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] maxv);
        return (v == 6'd0) ? maxv : v - 6'd1;
    endfunction

    // Binary 0..59 to {tens, units}; units computed modulo 16 since it is < 10.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [3:0] t10;
        logic [3:0] u;
        if (v >= 6'd50)      t = 4'd5;
        else if (v >= 6'd40) t = 4'd4;
        else if (v >= 6'd30) t = 4'd3;
        else if (v >= 6'd20) t = 4'd2;
        else if (v >= 6'd10) t = 4'd1;
        else                 t = 4'd0;
        t10 = (t << 3) + (t << 1);
        u   = v[3:0] - t10;
        return {t, u};
    endfunction

    state_t     state, state_nx;
    logic       mode_q, add_q, sub_q;
    logic       mode_ev, add_ev, sub_ev;
    logic [5:0] hh, mm, ss, ah, am;
    logic       armed, blink, skip, alarm;
    logic [7:0] alarm_cnt;
    logic [3:0] add_cnt, sub_cnt;

    logic       add_only, sub_only, editing, counting, tick;
    logic       add_rep, sub_rep, add_step, sub_step, alarm_hit;
    logic [5:0] hh_t, mm_t, ss_t;

    assign mode_o  = state;
    assign alarm_o = alarm;

    // Registered rising-edge detection of the debounced button levels.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q  <= 1'b0;
            add_q   <= 1'b0;
            sub_q   <= 1'b0;
            mode_ev <= 1'b0;
            add_ev  <= 1'b0;
            sub_ev  <= 1'b0;
        end else begin
            mode_q  <= mode_button;
            add_q   <= add_button;
            sub_q   <= sub_button;
            mode_ev <= mode_button & ~mode_q;
            add_ev  <= add_button & ~add_q;
            sub_ev  <= sub_button & ~sub_q;
        end
    end

    // Mode state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nx;
    end

    // Next mode and per-cycle control decisions.
    always_comb begin
        state_nx = state;
        if (mode_ev) begin
            case (state)
                RUN:     state_nx = SET_H;
                SET_H:   state_nx = SET_M;
                SET_M:   state_nx = SET_S;
                SET_S:   state_nx = SET_AH;
                SET_AH:  state_nx = SET_AM;
                default: state_nx = RUN;
            endcase
        end

        add_only = add_ev & ~sub_ev & ~mode_ev;
        sub_only = sub_ev & ~add_ev & ~mode_ev;
        editing  = (state != RUN);
        counting = (state == RUN) || (state == SET_AH) || (state == SET_AM);
        tick     = pulse_1hz & counting & ~skip;

        add_rep  = editing & ~mode_ev & pulse_500ms & add_button & ~sub_button & (add_cnt == HOLD);
        sub_rep  = editing & ~mode_ev & pulse_500ms & sub_button & ~add_button & (sub_cnt == HOLD);
        add_step = editing & (add_only | add_rep);
        sub_step = editing & (sub_only | sub_rep);

        ss_t = hh_t_dummy_free_ss();
        mm_t = mm;
        hh_t = hh;
        if (ss == 6'd59) begin
            if (mm == 6'd59) begin
                mm_t = 6'd0;
                hh_t = wrap_inc(hh, 6'd23);
            end else begin
                mm_t = mm + 6'd1;
            end
        end

        alarm_hit = tick & armed & (hh_t == ah) & (mm_t == am) & (ss_t == 6'd0);
    end

    function automatic logic [5:0] hh_t_dummy_free_ss();
        return wrap_inc(ss, 6'd59);
    endfunction

    // Auto-repeat hold counters: count 500 ms ticks while one button is held alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            add_cnt <= '0;
            sub_cnt <= '0;
        end else if (mode_ev) begin
            add_cnt <= '0;
            sub_cnt <= '0;
        end else begin
            if (!add_button || sub_button)           add_cnt <= '0;
            else if (pulse_500ms && add_cnt != HOLD) add_cnt <= add_cnt + 4'd1;
            if (!sub_button || add_button)           sub_cnt <= '0;
            else if (pulse_500ms && sub_cnt != HOLD) sub_cnt <= sub_cnt + 4'd1;
        end
    end

    // Time counting, field editing, arming and 1 Hz phase restart.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hh    <= '0;
            mm    <= '0;
            ss    <= '0;
            ah    <= '0;
            am    <= '0;
            armed <= 1'b0;
            skip  <= 1'b0;
        end else begin
            if (tick) begin
                hh <= hh_t;
                mm <= mm_t;
                ss <= ss_t;
            end
            if (pulse_1hz) skip <= 1'b0;
            case (state)
                RUN: if (sub_only) armed <= ~armed;
                SET_H: begin
                    if (add_step)      hh <= wrap_inc(hh, 6'd23);
                    else if (sub_step) hh <= wrap_dec(hh, 6'd23);
                end
                SET_M: begin
                    if (add_step)      mm <= wrap_inc(mm, 6'd59);
                    else if (sub_step) mm <= wrap_dec(mm, 6'd59);
                end
                SET_S: begin
                    if (add_step)      ss <= wrap_inc(ss, 6'd59);
                    else if (sub_step) ss <= wrap_dec(ss, 6'd59);
                    if (add_step || sub_step) skip <= 1'b1;
                end
                SET_AH: begin
                    if (add_step)      ah <= wrap_inc(ah, 6'd23);
                    else if (sub_step) ah <= wrap_dec(ah, 6'd23);
                end
                SET_AM: begin
                    if (add_step)      am <= wrap_inc(am, 6'd59);
                    else if (sub_step) am <= wrap_dec(am, 6'd59);
                end
                default: ;
            endcase
        end
    end

    // Alarm output: set on the matching tick, cleared by timeout, silence, disarm or mode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alarm     <= 1'b0;
            alarm_cnt <= '0;
        end else if (mode_ev || (state == RUN && (add_only || (sub_only && armed)))) begin
            alarm     <= 1'b0;
            alarm_cnt <= '0;
        end else if (alarm_hit) begin
            alarm     <= 1'b1;
            alarm_cnt <= '0;
        end else if (alarm && pulse_1hz) begin
            if (alarm_cnt == ALARM_END) alarm <= 1'b0;
            else                        alarm_cnt <= alarm_cnt + 8'd1;
        end
    end

    // Blink phase: toggles every 500 ms, restarts on mode change.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)            blink <= 1'b0;
        else if (mode_ev)     blink <= 1'b0;
        else if (pulse_500ms) blink <= ~blink;
    end

    logic       show_alarm, sep_dp, blank_h, blank_m, blank_s, h_tens_en;
    logic [5:0] hsrc, msrc, hdisp;
    logic [7:0] hb, mb, sb;
    logic [5:0] d1_nx, d2_nx, d3_nx, d4_nx, d5_nx, d6_nx, d7_nx, d8_nx;

    // Digit code composition from the current state.
    always_comb begin
        show_alarm = (state == SET_AH) || (state == SET_AM);
        hsrc       = show_alarm ? ah : hh;
        msrc       = show_alarm ? am : mm;
        hdisp      = hsrc;
        if (HOUR_12 != 0) begin
            if (hsrc == 6'd0)      hdisp = 6'd12;
            else if (hsrc > 6'd12) hdisp = hsrc - 6'd12;
        end
        hb = to_bcd(hdisp);
        mb = to_bcd(msrc);
        sb = to_bcd(ss);

        sep_dp    = (state == RUN) ? ~blink : 1'b1;
        blank_h   = blink & ((state == SET_H) || (state == SET_AH));
        blank_m   = blink & ((state == SET_M) || (state == SET_AM));
        blank_s   = blink & (state == SET_S);
        h_tens_en = ~blank_h & ((HOUR_12 == 0) || (hb[7:4] != 4'd0));

        d8_nx = {h_tens_en, hb[7:4], 1'b0};
        d7_nx = {~blank_h,  hb[3:0], sep_dp};
        d6_nx = {~blank_m,  mb[7:4], 1'b0};
        d5_nx = {~blank_m,  mb[3:0], sep_dp};
        d4_nx = show_alarm ? '0 : {~blank_s, sb[7:4], 1'b0};
        d3_nx = show_alarm ? '0 : {~blank_s, sb[3:0], 1'b0};
        d1_nx = (show_alarm || (state == RUN && armed)) ? {1'b1, 4'hA, 1'b0} : '0;
        d2_nx = (state == RUN && HOUR_12 != 0 && hh >= 6'd12) ? {1'b1, 4'h0, 1'b1} : '0;
    end

    // Registered digit outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d8 <= DIG_ZERO;
            d7 <= DIG_ZERO_DP;
            d6 <= DIG_ZERO;
            d5 <= DIG_ZERO_DP;
            d4 <= DIG_ZERO;
            d3 <= DIG_ZERO;
            d2 <= '0;
            d1 <= '0;
        end else begin
            d8 <= d8_nx;
            d7 <= d7_nx;
            d6 <= d6_nx;
            d5 <= d5_nx;
            d4 <= d4_nx;
            d3 <= d3_nx;
            d2 <= d2_nx;
            d1 <= d1_nx;
        end
    end

endmodule

// File: tb/tb_timekeeper_ctrl.sv
// Directed self-checking bench for timekeeper_ctrl: a 24-hour instance and a
// 12-hour instance share the same stimulus.
module tb_timekeeper_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic pulse_1hz = 1'b0, pulse_500ms = 1'b0;
    logic mode_button = 1'b0, add_button = 1'b0, sub_button = 1'b0;

    logic [5:0] a1, a2, a3, a4, a5, a6, a7, a8;
    logic [5:0] b1, b2, b3, b4, b5, b6, b7, b8;
    logic       a_alarm, b_alarm;
    logic [2:0] a_mode, b_mode;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    timekeeper_ctrl #(.HOUR_12(0), .REPEAT_HOLD(2), .ALARM_LEN_S(3)) dut24 (
        .clock(clock), .reset(reset), .pulse_1hz(pulse_1hz), .pulse_500ms(pulse_500ms),
        .mode_button(mode_button), .add_button(add_button), .sub_button(sub_button),
        .d1(a1), .d2(a2), .d3(a3), .d4(a4), .d5(a5), .d6(a6), .d7(a7), .d8(a8),
        .alarm_o(a_alarm), .mode_o(a_mode));

    timekeeper_ctrl #(.HOUR_12(1), .REPEAT_HOLD(2), .ALARM_LEN_S(3)) dut12 (
        .clock(clock), .reset(reset), .pulse_1hz(pulse_1hz), .pulse_500ms(pulse_500ms),
        .mode_button(mode_button), .add_button(add_button), .sub_button(sub_button),
        .d1(b1), .d2(b2), .d3(b3), .d4(b4), .d5(b5), .d6(b6), .d7(b7), .d8(b8),
        .alarm_o(b_alarm), .mode_o(b_mode));

    function automatic logic [5:0] dg(input logic en, input logic [3:0] v, input logic dp);
        return {en, v, dp};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic m, input logic a, input logic s);
        mode_button = m; add_button = a; sub_button = s;
        step();
        mode_button = 1'b0; add_button = 1'b0; sub_button = 1'b0;
        step();
    endtask

    task automatic tick1();
        pulse_1hz = 1'b1;
        step();
        pulse_1hz = 1'b0;
    endtask

    task automatic half();
        pulse_500ms = 1'b1;
        step();
        pulse_500ms = 1'b0;
    endtask

    initial begin
        step(); step();
        // Reset values while reset is held
        chk("rst_d8", a8, dg(1, 4'd0, 0));
        chk("rst_d7", a7, dg(1, 4'd0, 1));
        chk("rst_d5", a5, dg(1, 4'd0, 1));
        chk("rst_d3", a3, dg(1, 4'd0, 0));
        chk("rst_d2", a2, 6'd0);
        chk("rst_d1", a1, 6'd0);
        chk("rst_mode", a_mode, 3'd0);
        chk("rst_alarm", a_alarm, 1'b0);
        reset = 1'b0;
        step();

        // 61 seconds in RUN -> 00.01.01
        for (int i = 0; i < 61; i++) tick1();
        step();
        chk("run61_d7", a7, dg(1, 4'd0, 1));
        chk("run61_d5", a5, dg(1, 4'd1, 1));
        chk("run61_d4", a4, dg(1, 4'd0, 0));
        chk("run61_d3", a3, dg(1, 4'd1, 0));
        chk("run61_mode", a_mode, 3'd0);
        chk("run61_alarm", a_alarm, 1'b0);

        // Preset 23:59:59 by decrementing each field through its wrap
        press(1, 0, 0);
        chk("seth_mode", a_mode, 3'd1);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1); press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1); press(0, 0, 1);
        tick1();
        step();
        chk("sets_d8", a8, dg(1, 4'd2, 0));
        chk("sets_d7", a7, dg(1, 4'd3, 1));
        chk("sets_d5", a5, dg(1, 4'd9, 1));
        chk("sets_frozen_d3", a3, dg(1, 4'd9, 0));
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        chk("back_run", a_mode, 3'd0);
        tick1();
        step();
        chk("wrap_d8", a8, dg(1, 4'd0, 0));
        chk("wrap_d7", a7, dg(1, 4'd0, 1));
        chk("wrap_d5", a5, dg(1, 4'd0, 1));
        chk("wrap_d3", a3, dg(1, 4'd0, 0));
        chk("wrap_noalarm", a_alarm, 1'b0);

        // SET_M: 0 -1 -> 59, then held add with auto-repeat
        press(1, 0, 0); press(1, 0, 0);
        press(0, 0, 1);
        step();
        chk("setm_d6", a6, dg(1, 4'd5, 0));
        chk("setm_d5", a5, dg(1, 4'd9, 1));
        chk("setm_hours", a7, dg(1, 4'd0, 1));
        add_button = 1'b1;
        step(); step();
        half(); half();
        step();
        chk("hold_norep", a5, dg(1, 4'd0, 1));
        half(); half(); half();
        add_button = 1'b0;
        step();
        chk("hold_d5", a5, dg(0, 4'd3, 1));
        chk("hold_d6", a6, dg(0, 4'd0, 0));
        chk("hold_hours", a7, dg(1, 4'd0, 1));

        // Simultaneous events in SET_H
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        chk("reach_seth", a_mode, 3'd1);
        press(1, 1, 0);
        step();
        chk("modewins_mode", a_mode, 3'd2);
        chk("modewins_hours", a7, dg(1, 4'd0, 1));
        press(0, 1, 1);
        step();
        chk("addsub_d5", a5, dg(1, 4'd3, 1));
        chk("addsub_mode", a_mode, 3'd2);

        // Alarm 00:02
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        press(0, 1, 0); press(0, 1, 0);
        step();
        chk("setam_mode", a_mode, 3'd5);
        chk("setam_d5", a5, dg(1, 4'd2, 1));
        chk("setam_d4", a4, 6'd0);
        chk("setam_d1", a1, dg(1, 4'hA, 0));
        press(1, 0, 0);
        // Time 00:03:00 -> 00:01:59
        press(1, 0, 0); press(1, 0, 0);
        press(0, 0, 1); press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        tick1();
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        press(0, 0, 1);
        step();
        chk("armed_d1", a1, dg(1, 4'hA, 0));
        chk("pre_alarm", a_alarm, 1'b0);
        tick1();
        chk("alarm_on", a_alarm, 1'b1);
        tick1();
        chk("alarm_t1", a_alarm, 1'b1);
        tick1();
        chk("alarm_t2", a_alarm, 1'b1);
        tick1();
        chk("alarm_timeout", a_alarm, 1'b0);

        // Again from 00:01:59, silenced with add
        press(1, 0, 0); press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1); press(0, 0, 1); press(0, 0, 1); press(0, 0, 1);
        tick1();
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        tick1();
        chk("alarm_on2", a_alarm, 1'b1);
        press(0, 1, 0);
        chk("silenced", a_alarm, 1'b0);
        step();
        chk("still_armed", a1, dg(1, 4'hA, 0));

        // 12-hour display at 13:05:00
        press(1, 0, 0);
        for (int i = 0; i < 13; i++) press(0, 1, 0);
        press(1, 0, 0);
        press(0, 1, 0); press(0, 1, 0); press(0, 1, 0);
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        step();
        chk("h12_d8", b8, 6'd0);
        chk("h12_d7", b7, dg(1, 4'd1, 1));
        chk("h12_pm", b2, dg(1, 4'd0, 1));
        chk("h24_d8", a8, dg(1, 4'd1, 0));
        chk("h24_d7", a7, dg(1, 4'd3, 1));
        chk("h24_d2", a2, 6'd0);

        // 00:00:00 shows 12
        press(1, 0, 0);
        for (int i = 0; i < 11; i++) press(0, 1, 0);
        press(1, 0, 0);
        for (int i = 0; i < 5; i++) press(0, 0, 1);
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        step();
        chk("h12mid_d8", b8, dg(1, 4'd1, 0));
        chk("h12mid_d7", b7, dg(1, 4'd2, 1));
        chk("h12mid_am", b2, 6'd0);
        chk("h12mid_d5", b5, dg(1, 4'd0, 1));

        // Asynchronous reset in SET_AH
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        chk("pre_rst_mode", a_mode, 3'd4);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_mode", a_mode, 3'd0);
        chk("arst_alarm", a_alarm, 1'b0);
        chk("arst_d8", a8, dg(1, 4'd0, 0));
        chk("arst_d7", a7, dg(1, 4'd0, 1));
        chk("arst_d4", a4, dg(1, 4'd0, 0));
        chk("arst_d1", a1, 6'd0);
        chk("arst12_d7", b7, dg(1, 4'd0, 1));
        step();
        reset = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
